// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage, one bit per cycle.
// Ports: clk/rst (async, active-low), start/op/rs1_rdata/rs2_rdata/rd_waddr (op request),
//   flush (abort), hold_o (upstream stall), result_valid_o/result_o/rd_waddr_o (writeback).
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_rdata,
  input  logic [XLEN-1:0] rs2_rdata,
  input  logic [4:0]      rd_waddr,
  input  logic            flush,
  output logic            hold_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_waddr_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d, step, prod;
  logic [XLEN-1:0] md_q, md_d, res_q, res_d, abs_a, abs_b, spec_res, qr, qr_s, fin;
  logic [XLEN:0] mul_sum, rsh, diff;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] rd_q, rd_d, rdo_q, rdo_d;
  logic [2:0] op_q, op_d;
  logic neg_q, neg_d, sa, sb, div0, ovf, special;
  // Signed operand A: MULH, MULHSU, DIV, REM. Signed operand B: MULH, DIV, REM.
  assign sa = (op[2] ? ~op[0] : op[1] ^ op[0]) & rs1_rdata[XLEN-1];
  assign sb = (op == 3'd1 || op == 3'd4 || op == 3'd6) & rs2_rdata[XLEN-1];
  assign abs_a = sa ? -rs1_rdata : rs1_rdata;
  assign abs_b = sb ? -rs2_rdata : rs2_rdata;
  assign div0 = rs2_rdata == '0;
  assign ovf = ~op[0] & (rs1_rdata == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_rdata);
  assign special = op[2] & (div0 | ovf);
  assign spec_res = div0 ? (op[1] ? rs1_rdata : '1) : (op[1] ? '0 : rs1_rdata);
  // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, md_q} : '0);
  assign rsh = acc_q[2*XLEN-1:XLEN-1];
  assign diff = rsh - {1'b0, md_q};
  assign step = !op_q[2] ? {mul_sum, acc_q[XLEN-1:1]}
              : diff[XLEN] ? {rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
              : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign prod = neg_q ? -step : step;
  assign qr = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
  assign qr_s = neg_q ? -qr : qr;
  assign fin = op_q[2] ? qr_s : (op_q == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    md_d = md_q;
    neg_d = neg_q;
    op_d = op_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    res_d = res_q;
    rdo_d = rdo_q;
    if (flush) state_d = IDLE;
    else if (state_q == IDLE && start) begin
      op_d = op;
      rd_d = rd_waddr;
      cnt_d = '0;
      neg_d = (op[2] & op[1]) ? sa : sa ^ sb;
      md_d = op[2] ? abs_b : abs_a;
      acc_d = {{XLEN{1'b0}}, op[2] ? abs_a : abs_b};
      state_d = special ? DONE : BUSY;
      res_d = special ? spec_res : res_q;
      rdo_d = special ? rd_waddr : rdo_q;
    end else if (state_q == BUSY) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = DONE;
        res_d = fin;
        rdo_d = rd_q;
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      md_q <= '0;
      neg_q <= 1'b0;
      op_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
      res_q <= '0;
      rdo_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      md_q <= md_d;
      neg_q <= neg_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      res_q <= res_d;
      rdo_q <= rdo_d;
    end
  end
  // hold_o is gated by rst so every output reads 0 while reset is asserted.
  assign hold_o = rst & ((state_q == IDLE & start & ~flush) | state_q == BUSY);
  assign result_valid_o = state_q == DONE & ~flush;
  assign result_o = res_q;
  assign rd_waddr_o = rdo_q;
endmodule
